// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared types and constants for the writeback arbiter: default
//               widths, the register-file entry layout and the x0 address.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int WB_NUM_SRC    = 2;
    localparam int WB_XLEN       = 32;
    localparam int WB_REG_ADDR_W = 5;
    localparam int WB_FIFO_DEPTH = 2;

    // Address of the hard-wired zero register; writes to it are swallowed.
    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic [WB_REG_ADDR_W-1:0] addr;
        logic [WB_XLEN-1:0]       data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_src_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_src_fifo
// Description : Per-source result FIFO. Push is refused when full, even when
//               a pop happens in the same cycle. Flush empties it and wins
//               over concurrent push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_src_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_entry,
    output logic [WIDTH-1:0]           o_entry,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_entry = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Pointer and occupancy bookkeeping; flush overrides any push/pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage array; contents are don't-care until the count covers them.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_entry;
    end

endmodule
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter
// Description : Merges NUM_SRC result streams into one registered register-
//               file write port. One FIFO entry is drained per cycle; x0
//               writes are consumed without asserting reg_wr_en.
//               Build macro WB_ARB_RR_EN selects round-robin arbitration;
//               without it the lowest-index non-empty source wins.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_SRC    = WB_NUM_SRC,
    parameter int XLEN       = WB_XLEN,
    parameter int REG_ADDR_W = WB_REG_ADDR_W,
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC*XLEN-1:0]       src_data,
    output logic                          reg_wr_en,
    output logic [REG_ADDR_W-1:0]         reg_wr_addr,
    output logic [XLEN-1:0]               reg_wr_data,
    output logic                          busy
);

    localparam int EW = REG_ADDR_W + XLEN;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]    w_push;
    logic [NUM_SRC-1:0]    w_pop;
    logic [NUM_SRC-1:0]    w_full;
    logic [NUM_SRC-1:0]    w_empty;
    logic [EW-1:0]         w_head [NUM_SRC];
    logic [NUM_SRC*CW-1:0] w_count;
    logic                  w_unused_count;

    logic                  w_gnt_vld;
    logic [PW-1:0]         w_gnt_idx;
    logic [EW-1:0]         w_gnt_entry;
    logic [REG_ADDR_W-1:0] w_gnt_addr;

    logic                  r_wr_en;
    logic [REG_ADDR_W-1:0] r_wr_addr;
    logic [XLEN-1:0]       r_wr_data;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            assign src_ready[i] = !w_full[i];
            assign w_push[i]    = src_valid[i] && !w_full[i];
            assign w_pop[i]     = w_gnt_vld && (w_gnt_idx == PW'(i));

            wb_src_fifo #(
                .WIDTH (EW),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .reset_n (reset_n),
                .i_push  (w_push[i]),
                .i_pop   (w_pop[i]),
                .i_flush (flush),
                .i_entry ({src_addr[i*REG_ADDR_W +: REG_ADDR_W],
                           src_data[i*XLEN +: XLEN]}),
                .o_entry (w_head[i]),
                .o_full  (w_full[i]),
                .o_empty (w_empty[i]),
                .o_count (w_count[i*CW +: CW])
            );
        end
    endgenerate

    // Occupancy is exported by the FIFO for observability only.
    assign w_unused_count = ^w_count;

    assign busy        = |(~w_empty);
    assign w_gnt_entry = w_head[w_gnt_idx];
    assign w_gnt_addr  = w_gnt_entry[EW-1 -: REG_ADDR_W];

`ifdef WB_ARB_RR_EN
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_cand;

    // Round-robin grant: first non-empty source at or after the pointer.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_cand = PW'((int'(r_ptr) + k) % NUM_SRC);
            if (!w_gnt_vld && !w_empty[w_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    // Pointer advances past the granted source; flush restarts at source 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (flush) begin
            r_ptr <= '0;
        end else if (w_gnt_vld) begin
            r_ptr <= (w_gnt_idx == PW'(NUM_SRC - 1)) ? '0 : w_gnt_idx + PW'(1);
        end
    end
`else
    // Fixed-priority grant: lowest-index non-empty source wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (!w_empty[k]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = PW'(k);
            end
        end
    end
`endif

    // Registered write port; address/data hold when nothing is granted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (flush) begin
            r_wr_en   <= 1'b0;
        end else if (w_gnt_vld) begin
            r_wr_en   <= (w_gnt_addr != REG_ADDR_W'(REG_ZERO));
            r_wr_addr <= w_gnt_addr;
            r_wr_data <= w_gnt_entry[XLEN-1:0];
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

    assign reg_wr_en   = r_wr_en;
    assign reg_wr_addr = r_wr_addr;
    assign reg_wr_data = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_arbiter
// Description : Directed bench for writeback_arbiter (NUM_SRC=2 defaults).
//               Per-cycle vector table plus hand sequences for contention,
//               drain and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic [1:0]  src_valid;
    logic [1:0]  src_ready;
    logic [9:0]  src_addr;
    logic [63:0] src_data;
    logic        reg_wr_en;
    logic [4:0]  reg_wr_addr;
    logic [31:0] reg_wr_data;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    writeback_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_addr    (src_addr),
        .src_data    (src_data),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .busy        (busy)
    );

    typedef struct {
        logic        fl;
        logic [1:0]  vld;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        en;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        bsy;
        logic [1:0]  rdy;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic [1:0] vld,
                         input logic [4:0] a0, input logic [4:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        flush     = fl;
        src_valid = vld;
        src_addr  = {a1, a0};
        src_data  = {d1, d0};
    endtask

    initial begin
        int pulses;
        int waited;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic [1:0]  er;

        // Row: flush, valid, a0, a1, d0, d1 | en, addr, data, busy, ready
        tbl[0]  = '{0, 2'b01, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0,  0, 5'd0, 32'h0,        1, 2'b11};
        tbl[1]  = '{0, 2'b00, 5'd0, 5'd0, 32'h0,        32'h0,  1, 5'd3, 32'hDEADBEEF, 0, 2'b11};
        tbl[2]  = '{0, 2'b00, 5'd0, 5'd0, 32'h0,        32'h0,  0, 5'd3, 32'hDEADBEEF, 0, 2'b11};
        tbl[3]  = '{0, 2'b01, 5'd0, 5'd0, 32'h1234,     32'h0,  0, 5'd3, 32'hDEADBEEF, 1, 2'b11};
        tbl[4]  = '{0, 2'b00, 5'd0, 5'd0, 32'h0,        32'h0,  0, 5'd0, 32'h1234,     0, 2'b11};
        tbl[5]  = '{0, 2'b10, 5'd0, 5'd2, 32'h0,        32'h22, 0, 5'd0, 32'h1234,     1, 2'b11};
        tbl[6]  = '{0, 2'b10, 5'd0, 5'd5, 32'h0,        32'h55, 1, 5'd2, 32'h22,       1, 2'b11};
        tbl[7]  = '{0, 2'b10, 5'd0, 5'd7, 32'h0,        32'h77, 1, 5'd5, 32'h55,       1, 2'b11};
        tbl[8]  = '{0, 2'b00, 5'd0, 5'd0, 32'h0,        32'h0,  1, 5'd7, 32'h77,       0, 2'b11};
        tbl[9]  = '{0, 2'b00, 5'd0, 5'd0, 32'h0,        32'h0,  0, 5'd7, 32'h77,       0, 2'b11};
        tbl[10] = '{0, 2'b11, 5'd10, 5'd11, 32'hA,      32'hB,  0, 5'd7, 32'h77,       1, 2'b11};
        tbl[11] = '{1, 2'b10, 5'd0, 5'd12, 32'h0,       32'hC,  0, 5'd7, 32'h77,       0, 2'b11};
        tbl[12] = '{0, 2'b00, 5'd0, 5'd0, 32'h0,        32'h0,  0, 5'd7, 32'h77,       0, 2'b11};
        tbl[13] = '{0, 2'b00, 5'd0, 5'd0, 32'h0,        32'h0,  0, 5'd7, 32'h77,       0, 2'b11};

        reset_n = 1'b0;
        drive(0, 2'b00, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst.en",    32'(reg_wr_en),   32'd0);
        chk("rst.addr",  32'(reg_wr_addr), 32'd0);
        chk("rst.data",  reg_wr_data,      32'd0);
        chk("rst.busy",  32'(busy),        32'd0);
        chk("rst.ready", 32'(src_ready),   32'd3);
        @(negedge clk);
        reset_n = 1'b1;

        // Table: latency, x0 drop, single-source back-to-back, flush
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].fl, tbl[i].vld, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d.en", i),    32'(reg_wr_en),   32'(tbl[i].en));
            chk($sformatf("row%0d.addr", i),  32'(reg_wr_addr), 32'(tbl[i].ea));
            chk($sformatf("row%0d.data", i),  reg_wr_data,      tbl[i].ed);
            chk($sformatf("row%0d.busy", i),  32'(busy),        32'(tbl[i].bsy));
            chk($sformatf("row%0d.ready", i), 32'(src_ready),   32'(tbl[i].rdy));
        end

        // Contention: both sources valid for 8 cycles from empty, pointer at 0
        for (int c = 1; c <= 8; c++) begin
            drive(0, 2'b11, 5'd1, 5'd2, 32'(100 + c), 32'(200 + c));
            @(posedge clk);
            #1;
            if (c == 1) begin
                chk("cont1.en",    32'(reg_wr_en), 32'd0);
                chk("cont1.ready", 32'(src_ready), 32'd3);
            end else begin
`ifdef WB_ARB_RR_EN
                ea = (c % 2 == 0) ? 5'd1 : 5'd2;
                er = (c % 2 == 0) ? 2'b01 : 2'b10;
                case (c)
                    2: ed = 32'd101;
                    3: ed = 32'd201;
                    4: ed = 32'd102;
                    5: ed = 32'd202;
                    6: ed = 32'd103;
                    7: ed = 32'd204;
                    default: ed = 32'd105;
                endcase
`else
                ea = 5'd1;
                er = 2'b01;
                ed = 32'(100 + c - 1);
`endif
                chk($sformatf("cont%0d.en", c),    32'(reg_wr_en),   32'd1);
                chk($sformatf("cont%0d.addr", c),  32'(reg_wr_addr), 32'(ea));
                chk($sformatf("cont%0d.data", c),  reg_wr_data,      ed);
                chk($sformatf("cont%0d.ready", c), 32'(src_ready),   32'(er));
            end
        end

        // Drain: exactly three entries remain queued in either build
        drive(0, 2'b00, 0, 0, 0, 0);
        pulses = 0;
        waited = 0;
        while (busy && waited < 10) begin
            @(posedge clk);
            #1;
            waited++;
            if (reg_wr_en) pulses++;
        end
        @(posedge clk);
        #1;
        if (reg_wr_en) pulses++;
        chk("drain.busy",   32'(busy),  32'd0);
        chk("drain.writes", 32'(pulses), 32'd3);

        // Asynchronous reset with three entries pending
        drive(0, 2'b11, 5'd13, 5'd14, 32'h13, 32'h14);
        @(posedge clk);
        #1;
        drive(0, 2'b11, 5'd15, 5'd16, 32'h15, 32'h16);
        @(posedge clk);
        #1;
        chk("pre_rst.en",   32'(reg_wr_en), 32'd1);
        chk("pre_rst.busy", 32'(busy),      32'd1);
        drive(0, 2'b00, 0, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst.en",    32'(reg_wr_en),   32'd0);
        chk("arst.addr",  32'(reg_wr_addr), 32'd0);
        chk("arst.data",  reg_wr_data,      32'd0);
        chk("arst.busy",  32'(busy),        32'd0);
        chk("arst.ready", 32'(src_ready),   32'd3);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst%0d.en", c),   32'(reg_wr_en), 32'd0);
            chk($sformatf("post_rst%0d.busy", c), 32'(busy),      32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
